alert_initiator: RTL and testbench

// - Initiator side of the active-low alert line that the fan/misc logic consumes as irq_alert_n.
// - Debounces N_SRC active-low event sources (thermal, error, fan fault) and latches them as pending.
// - Drives alert_n low with a guaranteed minimum width, then waits for a host acknowledge.
// - Retries on acknowledge timeout. Sits beside Misc under PwrSequence and is clocked by the same free-running 1 ms tick.

---
 rtl/alert_initiator_pkg.sv | 23 ++
 rtl/alert_initiator_evt_debounce.sv | 43 ++++
 rtl/alert_initiator.sv | 141 ++++++++++++++
 tb/tb_alert_initiator.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alert_initiator_pkg.sv
// Shared types and default timing constants for the power-sequencing alert logic.
// All times are in 1 ms ticks of the free-running cnt1ms_done strobe.
package PwrSeqPackage;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    WAIT_ACK,
    REARM
  } alert_state_t;

  localparam int DEF_N_SRC          = 4;
  localparam int DEF_DEBOUNCE_MS    = 2;
  localparam int DEF_MIN_ASSERT_MS  = 100;
  localparam int DEF_ACK_TIMEOUT_MS = 500;
  localparam int DEF_REARM_MS       = 10;
  localparam int RETRY_W            = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alert_initiator_evt_debounce.sv
// One event source: 2-FF synchronizer, ms-quantised low-time counter and a
// single accept pulse per low period.
module evt_debounce
  import PwrSeqPackage::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_evt_n,
  output logic o_accept
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          w_advance;

  // Counter stops at DEBOUNCE_MS, so the terminal step happens once per low period.
  assign w_advance = i_tick && !r_sync2 && (r_cnt != CW'(DEBOUNCE_MS));
  assign o_accept  = w_advance && (r_cnt == CW'(DEBOUNCE_MS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: synchronizer resets to the idle (high) level so leaving reset never looks like an event.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_evt_n;
      r_sync2 <= r_sync1;
      if (r_sync2) begin
        r_cnt <= '0;
      end else if (w_advance) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alert_initiator.sv
// Alert initiator: latches debounced event sources as pending and drives the
// active-low alert line with minimum width, ack wait, timeout retry and re-arm.
module alert_initiator
  import PwrSeqPackage::*;
#(
  parameter int N_SRC          = DEF_N_SRC,
  parameter int DEBOUNCE_MS    = DEF_DEBOUNCE_MS,
  parameter int MIN_ASSERT_MS  = DEF_MIN_ASSERT_MS,
  parameter int ACK_TIMEOUT_MS = DEF_ACK_TIMEOUT_MS,
  parameter int REARM_MS       = DEF_REARM_MS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cnt1ms_done,
  input  logic [N_SRC-1:0]   evt_n,
  input  logic [N_SRC-1:0]   evt_mask,
  input  logic               alert_ack,
  output logic               alert_n,
  output logic [N_SRC-1:0]   evt_status,
  output logic [N_SRC-1:0]   evt_pending,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               busy
);

  localparam int MS_MAX = max_int(max_int(MIN_ASSERT_MS, ACK_TIMEOUT_MS), REARM_MS);
  localparam int MS_W   = $clog2(MS_MAX + 1);

  alert_state_t       r_state;
  logic [MS_W-1:0]    r_ms_cnt;
  logic               r_alert_n;
  logic               r_busy;
  logic [N_SRC-1:0]   r_status;
  logic [N_SRC-1:0]   r_pending;
  logic [RETRY_W-1:0] r_retry;

  logic [N_SRC-1:0]   w_accept;
  logic [N_SRC-1:0]   w_trigger;
  logic [N_SRC-1:0]   w_ack_clr;
  logic               w_ack;
  logic               w_assert_done;
  logic               w_ack_timeout;
  logic               w_rearm_done;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    evt_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (cnt1ms_done),
      .i_evt_n (evt_n[gi]),
      .o_accept(w_accept[gi])
    );
  end

  assign w_trigger = r_pending & ~evt_mask;
  assign w_ack     = (r_state == WAIT_ACK) && alert_ack;
  assign w_ack_clr = w_ack ? r_status : '0;

  // Each phase ends on the tick that completes its ms budget.
  assign w_assert_done = cnt1ms_done && (r_ms_cnt == MS_W'(MIN_ASSERT_MS - 1));
  assign w_ack_timeout = cnt1ms_done && (r_ms_cnt == MS_W'(ACK_TIMEOUT_MS - 1));
  assign w_rearm_done  = cnt1ms_done && (r_ms_cnt == MS_W'(REARM_MS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ms_cnt  <= '0;
      r_alert_n <= 1'b1;
      r_busy    <= 1'b0;
      r_status  <= '0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_trigger) begin
            r_state   <= ASSERT;
            r_ms_cnt  <= '0;
            r_status  <= w_trigger;
            r_alert_n <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ASSERT: begin
          if (w_assert_done) begin
            r_state  <= WAIT_ACK;
            r_ms_cnt <= '0;
          end else if (cnt1ms_done) begin
            r_ms_cnt <= r_ms_cnt + MS_W'(1);
          end
        end
        WAIT_ACK: begin
          if (w_ack) begin
            r_state   <= REARM;
            r_ms_cnt  <= '0;
            r_status  <= '0;
            r_alert_n <= 1'b1;
          end else if (w_ack_timeout) begin
            r_state   <= REARM;
            r_ms_cnt  <= '0;
            r_alert_n <= 1'b1;
            if (r_retry != '1) begin
              r_retry <= r_retry + RETRY_W'(1);
            end
          end else if (cnt1ms_done) begin
            r_ms_cnt <= r_ms_cnt + MS_W'(1);
          end
        end
        REARM: begin
          if (w_rearm_done) begin
            r_state  <= IDLE;
            r_ms_cnt <= '0;
            r_busy   <= 1'b0;
          end else if (cnt1ms_done) begin
            r_ms_cnt <= r_ms_cnt + MS_W'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ms_cnt <= '0;
        end
      endcase
    end
  end

  // NOTE: accepts are ORed in after the ack clear, so a bit set on the ack cycle survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_clr) | w_accept;
    end
  end

  assign alert_n     = r_alert_n;
  assign evt_status  = r_status;
  assign evt_pending = r_pending;
  assign retry_cnt   = r_retry;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alert_initiator.sv
// Directed bench for alert_initiator: a ms-level behavioural model is compared
// every cycle, plus literal checks at the scenario milestones.
module tb_alert_initiator;

  localparam int TICK_CLKS  = 4;
  localparam int DEB_MS     = 2;
  localparam int ASSERT_MS  = 100;
  localparam int TIMEOUT_MS = 500;
  localparam int REARM_MS_T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt1ms_done = 1'b0;
  logic [3:0] evt_n = 4'b1111;
  logic [3:0] evt_mask = 4'b0000;
  logic       alert_ack = 1'b0;
  logic       alert_n;
  logic [3:0] evt_status;
  logic [3:0] evt_pending;
  logic [3:0] retry_cnt;
  logic       busy;

  alert_initiator dut (
    .clk        (clk),
    .rst        (rst),
    .cnt1ms_done(cnt1ms_done),
    .evt_n      (evt_n),
    .evt_mask   (evt_mask),
    .alert_ack  (alert_ack),
    .alert_n    (alert_n),
    .evt_status (evt_status),
    .evt_pending(evt_pending),
    .retry_cnt  (retry_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // 1 ms tick: one cycle high every TICK_CLKS cycles, changed on negedges.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      cnt1ms_done = (ph == TICK_CLKS - 1);
      ph = (ph + 1) % TICK_CLKS;
    end
  end

  // Behavioural model: phase 0 idle, 1 alert held (min width), 2 awaiting ack, 3 re-arm.
  int         m_phase;
  int         m_left;
  int         m_low [4];
  logic [3:0] m_retry;
  logic [3:0] m_pend;
  logic [3:0] m_status;
  logic [3:0] m_seen1;
  logic [3:0] m_seen2;

  task automatic model_reset();
    m_phase  = 0;
    m_left   = 0;
    m_retry  = 4'd0;
    m_pend   = 4'b0000;
    m_status = 4'b0000;
    m_seen1  = 4'b1111;
    m_seen2  = 4'b1111;
    for (int i = 0; i < 4; i++) m_low[i] = 0;
  endtask

  task automatic model_step();
    logic [3:0] acc;
    logic [3:0] clr;
    acc = 4'b0000;
    clr = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (m_seen2[i]) begin
        m_low[i] = 0;
      end else if (cnt1ms_done && m_low[i] < DEB_MS) begin
        m_low[i]++;
        if (m_low[i] == DEB_MS) acc[i] = 1'b1;
      end
    end
    m_seen2 = m_seen1;
    m_seen1 = evt_n;
    case (m_phase)
      0: if ((m_pend & ~evt_mask) != 4'b0000) begin
        m_status = m_pend & ~evt_mask;
        m_phase  = 1;
        m_left   = ASSERT_MS;
      end
      1: if (cnt1ms_done) begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          m_left  = TIMEOUT_MS;
        end
      end
      2: if (alert_ack) begin
        clr      = m_status;
        m_status = 4'b0000;
        m_phase  = 3;
        m_left   = REARM_MS_T;
      end else if (cnt1ms_done) begin
        m_left--;
        if (m_left == 0) begin
          if (m_retry != 4'd15) m_retry++;
          m_phase = 3;
          m_left  = REARM_MS_T;
        end
      end
      default: if (cnt1ms_done) begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    m_pend = (m_pend & ~clr) | acc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every-cycle compare of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cycle {alert_n,busy,retry,status,pending}",
              {2'b00, alert_n, busy, retry_cnt, evt_status, evt_pending},
              {2'b00, !(m_phase == 1 || m_phase == 2), m_phase != 0, m_retry, m_status, m_pend});
      end
    end
  end

  task automatic wait_ms(input int n);
    repeat (n * TICK_CLKS) @(negedge clk);
  endtask

  task automatic wait_alert(input logic lvl, input int budget_ms, input string name);
    int k = 0;
    while (alert_n !== lvl && k < budget_ms * TICK_CLKS) begin
      @(negedge clk);
      k++;
    end
    check(name, alert_n, lvl);
  endtask

  task automatic pulse_ack();
    alert_ack = 1'b1;
    @(negedge clk);
    alert_ack = 1'b0;
  endtask

  task automatic source_low(input int idx, input int ms);
    evt_n[idx] = 1'b0;
    wait_ms(ms);
    evt_n[idx] = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset alert_n", alert_n, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset status/pending/retry", {evt_status, evt_pending, retry_cnt}, 12'h000);
    rst = 1'b0;
    wait_ms(2);

    // Single event on source 0, acked at ~150 ms.
    source_low(0, 5);
    check("single alert_n low", alert_n, 1'b0);
    check("single status", evt_status, 4'b0001);
    wait_ms(95);
    check("single min width", alert_n, 1'b0);
    wait_ms(50);
    pulse_ack();
    check("single ack release", alert_n, 1'b1);
    check("single pending cleared", evt_pending, 4'b0000);
    wait_ms(12);
    check("single back idle", busy, 1'b0);

    // 1 ms glitch on source 1 must not be accepted.
    source_low(1, 1);
    wait_ms(5);
    check("glitch alert_n", alert_n, 1'b1);
    check("glitch pending", evt_pending, 4'b0000);

    // Masked source 2 latches but does not alert until unmasked.
    evt_mask = 4'b0100;
    source_low(2, 5);
    check("masked pending", evt_pending, 4'b0100);
    check("masked alert_n", alert_n, 1'b1);
    evt_mask = 4'b0000;
    @(negedge clk);
    check("unmask alert_n", alert_n, 1'b0);
    check("unmask status", evt_status, 4'b0100);
    wait_ms(105);
    pulse_ack();
    check("unmask ack pending", evt_pending, 4'b0000);
    wait_ms(12);

    // Source 3 arrives while waiting for the ack of source 0.
    source_low(0, 5);
    wait_ms(110);
    source_low(3, 5);
    check("late pending", evt_pending, 4'b1001);
    check("late status unchanged", evt_status, 4'b0001);
    pulse_ack();
    check("late ack clears bit0", evt_pending, 4'b1000);
    check("late ack release", alert_n, 1'b1);
    wait_ms(8);
    check("late rearm hold", alert_n, 1'b1);
    wait_alert(1'b0, 5, "late realert");
    check("late new status", evt_status, 4'b1000);
    wait_ms(105);
    pulse_ack();
    check("late final pending", evt_pending, 4'b0000);
    wait_ms(12);

    // Ack timeouts: first retry, then saturation after 16.
    source_low(1, 5);
    check("timeout status", evt_status, 4'b0010);
    wait_alert(1'b1, 700, "timeout release");
    check("timeout retry 1", retry_cnt, 4'd1);
    check("timeout status held", evt_status, 4'b0010);
    wait_ms(8);
    check("timeout rearm hold", alert_n, 1'b1);
    wait_alert(1'b0, 6, "timeout reassert");
    check("timeout reassert status", evt_status, 4'b0010);
    for (int i = 0; i < 15; i++) begin
      wait_alert(1'b1, 700, "timeout loop release");
      wait_alert(1'b0, 15, "timeout loop reassert");
    end
    check("retry saturated", retry_cnt, 4'd15);

    // Asynchronous reset in the middle of an assertion.
    wait_ms(50);
    check("pre-reset asserted", alert_n, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async reset alert_n", alert_n, 1'b1);
    check("async reset outputs", {busy, retry_cnt, evt_status, evt_pending}, 13'h0000);
    @(negedge clk);
    rst = 1'b0;
    wait_ms(3);
    check("post reset idle", {alert_n, busy}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
